// File: rtl/rom_read_arbiter_if.sv
// Two-requester ROM read bus: request/grant/return per requester plus the shared ROM port.
interface rom_read_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req0;
   logic [ADDR_W-1:0] addr0;
   logic              gnt0;
   logic              rvalid0;
   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic              gnt1;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] data_from_rom;

   // Environment side: requesters plus the ROM data return.
   modport master (
      output req0, addr0, req1, addr1, data_from_rom,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, rom_en, rom_address
   );

   modport slave (
      input  req0, addr0, req1, addr1, data_from_rom,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, rom_en, rom_address
   );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin share of one ROM read port; rvalid ROM_LATENCY+2 cycles after grant, never stalls.
// Optional ROM_ARB_STATS_EN adds saturating 16-bit per-requester grant counters gnt_cnt0/gnt_cnt1.
module rom_read_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int ROM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   rom_read_arbiter_if.slave bus
`ifdef ROM_ARB_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
`endif
);

   typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_e;

   owner_e               last_gnt_q, last_gnt_d;
   logic                 gnt0, gnt1, gnt_any;
   logic [ADDR_W-1:0]    issue_addr;
   logic                 rom_en_q, rom_en_d;
   logic [ADDR_W-1:0]    rom_address_q, rom_address_d;
   logic [ROM_LATENCY:0] pipe_vld_q, pipe_vld_d;
   logic [ROM_LATENCY:0] pipe_own_q, pipe_own_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 rvalid0_q, rvalid0_d;
   logic                 rvalid1_q, rvalid1_d;

   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      issue_addr = bus.addr0;
      last_gnt_d = last_gnt_q;
      if (reset) begin
         if (bus.req0 && (!bus.req1 || last_gnt_q == OWN1)) begin
            gnt0 = 1'b1;
         end else if (bus.req1) begin
            gnt1 = 1'b1;
         end
      end
      if (gnt1) begin
         issue_addr = bus.addr1;
         last_gnt_d = OWN1;
      end else if (gnt0) begin
         last_gnt_d = OWN0;
      end
      gnt_any = gnt0 | gnt1;

      rom_en_d      = gnt_any;
      rom_address_d = gnt_any ? issue_addr : rom_address_q;

      // Stage k holds the access issued k+1 cycles ago; the last stage lines up with ROM data.
      pipe_vld_d = {pipe_vld_q[ROM_LATENCY-1:0], gnt_any};
      pipe_own_d = {pipe_own_q[ROM_LATENCY-1:0], gnt1};
      rvalid0_d  = pipe_vld_q[ROM_LATENCY] && !pipe_own_q[ROM_LATENCY];
      rvalid1_d  = pipe_vld_q[ROM_LATENCY] &&  pipe_own_q[ROM_LATENCY];
      rdata_d    = pipe_vld_q[ROM_LATENCY] ? bus.data_from_rom : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_gnt_q    <= OWN1;
         rom_en_q      <= 1'b0;
         rom_address_q <= '0;
         pipe_vld_q    <= '0;
         pipe_own_q    <= '0;
         rdata_q       <= '0;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
      end else begin
         last_gnt_q    <= last_gnt_d;
         rom_en_q      <= rom_en_d;
         rom_address_q <= rom_address_d;
         pipe_vld_q    <= pipe_vld_d;
         pipe_own_q    <= pipe_own_d;
         rdata_q       <= rdata_d;
         rvalid0_q     <= rvalid0_d;
         rvalid1_q     <= rvalid1_d;
      end
   end

   assign bus.gnt0        = gnt0;
   assign bus.gnt1        = gnt1;
   assign bus.rom_en      = rom_en_q;
   assign bus.rom_address = rom_address_q;
   assign bus.rvalid0     = rvalid0_q;
   assign bus.rvalid1     = rvalid1_q;
   assign bus.rdata       = rdata_q;

`ifdef ROM_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (gnt0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
      if (gnt1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench: one arbiter at ROM_LATENCY=1 and one at ROM_LATENCY=3, ROM contents = addr ^ 8'hA0.
module tb_rom_read_arbiter;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   rom_read_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
   rom_read_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

`ifdef ROM_ARB_STATS_EN
   logic [15:0] cnt0_a, cnt1_a, cnt0_b, cnt1_b;
`endif

   rom_read_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_LATENCY(1)) u0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
`ifdef ROM_ARB_STATS_EN
      ,
      .gnt_cnt0 (cnt0_a),
      .gnt_cnt1 (cnt1_a)
`endif
   );

   rom_read_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_LATENCY(3)) u3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
`ifdef ROM_ARB_STATS_EN
      ,
      .gnt_cnt0 (cnt0_b),
      .gnt_cnt1 (cnt1_b)
`endif
   );

   always #5 clk = ~clk;

   // ROM models: data valid LATENCY cycles after the address is sampled.
   logic [7:0] r3_s1, r3_s2;
   always @(posedge clk) begin
      bus0.data_from_rom <= bus0.rom_address ^ 8'hA0;
      r3_s1              <= bus3.rom_address ^ 8'hA0;
      r3_s2              <= r3_s1;
      bus3.data_from_rom <= r3_s2;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus0.req0 = 1'b0; bus0.req1 = 1'b0; bus0.addr0 = '0; bus0.addr1 = '0;
      bus3.req0 = 1'b0; bus3.req1 = 1'b0; bus3.addr0 = '0; bus3.addr1 = '0;

      // Reset: grants suppressed even with a request present.
      nxt();
      nxt();
      bus0.req0 = 1'b1; bus0.addr0 = 8'h05;
      mid();
      chk("rst_gnt0", bus0.gnt0, 0);
      chk("rst_rom_en", bus0.rom_en, 0);
      chk("rst_rom_address", bus0.rom_address, 0);
      chk("rst_rdata", bus0.rdata, 0);
      chk("rst_rvalid0", bus0.rvalid0, 0);
      chk("rst_rvalid1", bus0.rvalid1, 0);

      // Single read from requester 0, released in the same cycle as reset.
      nxt(); reset = 1'b1;
      mid();
      chk("t1_gnt0", bus0.gnt0, 1);
      chk("t1_gnt1", bus0.gnt1, 0);
      nxt(); bus0.req0 = 1'b0;
      mid();
      chk("t1_rom_en_T1", bus0.rom_en, 1);
      chk("t1_rom_addr_T1", bus0.rom_address, 8'h05);
      chk("t1_rvalid0_T1", bus0.rvalid0, 0);
      nxt(); mid();
      chk("t1_rom_en_T2", bus0.rom_en, 0);
      chk("t1_rom_addr_hold", bus0.rom_address, 8'h05);
      chk("t1_rvalid0_T2", bus0.rvalid0, 0);
      nxt(); mid();
      chk("t1_rvalid0_T3", bus0.rvalid0, 1);
      chk("t1_rdata_T3", bus0.rdata, 8'hA5);
      chk("t1_rvalid1_T3", bus0.rvalid1, 0);
      nxt(); mid();
      chk("t1_rvalid0_T4", bus0.rvalid0, 0);
      chk("t1_rdata_hold", bus0.rdata, 8'hA5);
      chk("t1_rvalid1_T4", bus0.rvalid1, 0);

      // Both requesting for 6 cycles after a fresh reset: alternate starting with 0.
      nxt(); reset = 1'b0;
      nxt(); reset = 1'b1;
      for (int i = 0; i < 9; i++) begin
         logic e_g0, e_g1, e_en, e_rv0, e_rv1;
         if (i > 0) nxt();
         bus0.req0 = (i < 6); bus0.addr0 = 8'h10;
         bus0.req1 = (i < 6); bus0.addr1 = 8'h20;
         mid();
         e_g0  = (i < 6) && (i % 2 == 0);
         e_g1  = (i < 6) && (i % 2 == 1);
         e_en  = (i >= 1) && (i <= 6);
         e_rv0 = (i >= 3) && ((i - 3) % 2 == 0);
         e_rv1 = (i >= 3) && ((i - 3) % 2 == 1);
         chk($sformatf("t2_gnt0_%0d", i), bus0.gnt0, e_g0);
         chk($sformatf("t2_gnt1_%0d", i), bus0.gnt1, e_g1);
         chk($sformatf("t2_rom_en_%0d", i), bus0.rom_en, e_en);
         if (e_en) chk($sformatf("t2_rom_addr_%0d", i), bus0.rom_address, (i % 2 == 1) ? 8'h10 : 8'h20);
         chk($sformatf("t2_rvalid0_%0d", i), bus0.rvalid0, e_rv0);
         chk($sformatf("t2_rvalid1_%0d", i), bus0.rvalid1, e_rv1);
         if (e_rv0 || e_rv1) chk($sformatf("t2_rdata_%0d", i), bus0.rdata, e_rv0 ? 8'hB0 : 8'h80);
      end

      // Requester 1 alone, back-to-back for 4 cycles.
      for (int i = 0; i < 8; i++) begin
         logic       e_rv1;
         logic [7:0] e_dat;
         nxt();
         bus0.req0 = 1'b0;
         bus0.req1 = (i < 4); bus0.addr1 = 8'(i);
         mid();
         e_rv1 = (i >= 3) && (i <= 6);
         e_dat = 8'(i - 3) ^ 8'hA0;
         chk($sformatf("t3_gnt1_%0d", i), bus0.gnt1, (i < 4));
         chk($sformatf("t3_gnt0_%0d", i), bus0.gnt0, 0);
         chk($sformatf("t3_rvalid1_%0d", i), bus0.rvalid1, e_rv1);
         chk($sformatf("t3_rvalid0_%0d", i), bus0.rvalid0, 0);
         if (e_rv1) chk($sformatf("t3_rdata_%0d", i), bus0.rdata, e_dat);
      end

      // Reset with two reads in flight.
      nxt(); bus0.req0 = 1'b1; bus0.addr0 = 8'h33; bus0.req1 = 1'b1; bus0.addr1 = 8'h44;
      mid();
      chk("t4_c0_gnt0", bus0.gnt0, 1);
      nxt(); bus0.req0 = 1'b0;
      mid();
      chk("t4_c1_gnt1", bus0.gnt1, 1);
      nxt(); reset = 1'b0; bus0.req0 = 1'b1; bus0.req1 = 1'b1;
      mid();
      chk("t4_c2_gnt0", bus0.gnt0, 0);
      chk("t4_c2_gnt1", bus0.gnt1, 0);
      nxt(); reset = 1'b1;
      mid();
      chk("t4_c3_gnt0", bus0.gnt0, 1);
      chk("t4_c3_gnt1", bus0.gnt1, 0);
      chk("t4_c3_rom_en", bus0.rom_en, 0);
      chk("t4_c3_rom_addr", bus0.rom_address, 0);
      chk("t4_c3_rdata", bus0.rdata, 0);
      chk("t4_c3_rvalid0", bus0.rvalid0, 0);
      chk("t4_c3_rvalid1", bus0.rvalid1, 0);
      for (int k = 4; k < 8; k++) begin
         nxt(); bus0.req0 = 1'b0; bus0.req1 = 1'b0;
         mid();
         chk($sformatf("t4_c%0d_rvalid0", k), bus0.rvalid0, (k == 6));
         chk($sformatf("t4_c%0d_rvalid1", k), bus0.rvalid1, 0);
         if (k == 6) chk("t4_c6_rdata", bus0.rdata, 8'h93);
      end

      // ROM_LATENCY=3 instance: single read at the top address.
      nxt(); bus3.req0 = 1'b1; bus3.addr0 = 8'hFF;
      mid();
      chk("t5_gnt0", bus3.gnt0, 1);
      for (int k = 1; k < 7; k++) begin
         nxt(); bus3.req0 = 1'b0;
         mid();
         if (k == 1) chk("t5_rom_addr", bus3.rom_address, 8'hFF);
         chk($sformatf("t5_rvalid0_%0d", k), bus3.rvalid0, (k == 5));
         chk($sformatf("t5_rvalid1_%0d", k), bus3.rvalid1, 0);
         if (k == 5) chk("t5_rdata", bus3.rdata, 8'h5F);
      end

`ifdef ROM_ARB_STATS_EN
      // Grant counters: cleared by reset, then 3 grants to 0 and 2 to 1.
      nxt(); reset = 1'b0;
      nxt(); reset = 1'b1; bus0.req0 = 1'b1; bus0.req1 = 1'b1;
      mid();
      chk("t6_cnt0_rst", cnt0_a, 0);
      chk("t6_cnt1_rst", cnt1_a, 0);
      nxt(); nxt(); nxt();
      nxt(); bus0.req1 = 1'b0;
      nxt(); bus0.req0 = 1'b0;
      mid();
      chk("t6_cnt0", cnt0_a, 3);
      chk("t6_cnt1", cnt1_a, 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares the single program ROM read port between two requesters.
- Requester 0 is the instruction fetch/decoder-feed sequencer; requester 1 is the operand/data table reader.
- Round-robin arbitration, one ROM access granted per cycle, fully pipelined.
- Read data is returned to the owning requester with a fixed latency.

Parameters:
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width (one byte).
- ROM_LATENCY, 1, ROM read latency in cycles: cycles from address sampled by the ROM to data valid. Legal range 1..4.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- req0  input  1  requester 0 read request
- addr0  input  ADDR_W  requester 0 address, held stable while req0 is high and not yet granted
- gnt0  output  1  combinational grant pulse; the request is accepted in the cycle req0&&gnt0
- rvalid0  output  1  one-cycle pulse; rdata belongs to requester 0
- req1  input  1  requester 1 read request
- addr1  input  ADDR_W  requester 1 address
- gnt1  output  1  grant pulse for requester 1
- rvalid1  output  1  return pulse for requester 1
- rdata  output  DATA_W  shared return data, qualified by rvalid0/rvalid1
- rom_en  output  1  registered ROM read enable
- rom_address  output  ADDR_W  registered ROM address
- data_from_rom  input  DATA_W  ROM read data

Behaviour:
- Reset: when reset==0 at a clk edge, all of the following are cleared:
  - gnt0/gnt1 forced 0 while reset is low
  - rvalid0=0, rvalid1=0, rdata=0, rom_en=0, rom_address=0
  - all in-flight pipeline entries cleared
  - round-robin pointer last_gnt=1, so requester 0 wins the first tie
- Arbitration, combinational from req0, req1 and last_gnt:
  - only req0 -> gnt0
  - only req1 -> gnt1
  - both -> grant the requester not equal to last_gnt
  - neither -> no grant
  - at most one of gnt0/gnt1 high in any cycle
- last_gnt updates only on a cycle with a grant; it is unchanged on idle cycles.
- Issue: in grant cycle T, the granted address is registered, so rom_address/rom_en are valid in cycle T+1. rom_en=0 in any cycle following a no-grant cycle. rom_address holds its last value when rom_en=0.
- Tracking: an owner pipeline of depth ROM_LATENCY+1 holds (valid, owner id), shifted every cycle. No stalls; requesters always accept return data.
- Return: data_from_rom is sampled into rdata at the edge ending cycle T+1+ROM_LATENCY. The matching rvalidN is high for exactly cycle T+2+ROM_LATENCY, i.e. cycle T+3 for ROM_LATENCY=1.
- rdata holds its value when no rvalid is asserted.
- Throughput: back-to-back grants every cycle. Return order equals grant order.
- Both requesters continuously requesting -> grants alternate 0,1,0,1...
- Requester rules:
  - req may be withdrawn before grant; nothing is issued.
  - After gnt, the requester may present a new address the next cycle; its next req is arbitrated normally.
  - A single requester alone may be granted every cycle.
- Reset mid-operation: all in-flight reads are dropped. No rvalid is asserted for them after reset is released. The first grant after release follows the reset pointer.
- A request arriving in the same cycle that reset is released is arbitrated normally.

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each).
  - Each counter increments on its requester's grant cycle and saturates at 16'hFFFF.
  - Both counters are cleared by reset.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then req0=1 addr0=8'h05 for one cycle, ROM_LATENCY=1, ROM returns 8'hA5 -> gnt0 in T, rom_address=8'h05 with rom_en=1 in T+1, rvalid0=1 and rdata=8'hA5 in T+3, rvalid1 never asserted.
- req0 and req1 both held high 6 cycles, addr0=8'h10, addr1=8'h20 -> grant order 0,1,0,1,0,1; rom_address sequence 10,20,10,20,10,20; rvalids alternate starting with rvalid0.
- req1 alone for 4 consecutive cycles, addr1=0..3 -> gnt1 every cycle; rvalid1 on 4 consecutive cycles with rdata=ROM[0..3] in order.
- Two grants in flight, reset driven low for one cycle -> no rvalid after reset; outputs zero; next simultaneous request grants requester 0.
- ROM_LATENCY=3, single req0 at address 8'hFF -> rvalid0 exactly 5 cycles after grant with rdata=ROM[8'hFF].
- ROM_ARB_STATS_EN defined, 3 grants to requester 0 and 2 to requester 1 -> gnt_cnt0=3, gnt_cnt1=2; both counters 0 after reset.
